// File: rtl/nano_pkg.sv
// Shared types and sizing for the NanoCPU memory responder and its byte-serial loader.
package nano_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 16;

  typedef enum logic [2:0] {
    L_IDLE,
    L_ADDR,
    L_CNT,
    L_HI,
    L_LO,
    L_FIN
  } ldState_t;

endpackage

// File: rtl/nano_ram.sv
// Single-port word store: asynchronous read, synchronous write, contents not reset.
module nano_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          ck,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge ck) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/nano_mem_loader.sv
// NanoCPU bus memory target with a byte-serial loader that holds the CPU in reset
// while it streams {base, count, hi, lo, hi, lo, ...} into the store.
module nano_mem_loader
  import nano_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] dataW,
  output logic [DW-1:0] dataR,
  input  logic          ce,
  input  logic          we,
  input  logic          ld_start,
  input  logic          ld_abort,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  output logic          cpu_hold,
  output logic          ld_done,
  output logic [AW:0]   words_loaded
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  ldState_t          state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DW/2-1:0]   hi_q, hi_d;
  logic [AW:0]       wl_q, wl_d;
  logic [AW:0]       n_total;
  logic              accept;
  logic              ld_wr;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= L_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      wl_q    <= wl_d;
    end
  end

  assign ld_ready = (state_q == L_ADDR) || (state_q == L_CNT) ||
                    (state_q == L_HI)   || (state_q == L_LO);
  assign accept   = ld_valid & ld_ready;
  // A count byte of zero stands for a full store of words.
  assign n_total  = (cnt_q == 8'd0) ? FULL_CNT : (AW+1)'(cnt_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    wl_d    = wl_q;
    ld_wr   = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (ld_start) begin
          state_d = L_ADDR;
          wl_d    = '0;
        end
      end
      L_ADDR: begin
        if (accept) begin
          ptr_d   = AW'(ld_byte);
          state_d = L_CNT;
        end
      end
      L_CNT: begin
        if (accept) begin
          cnt_d   = ld_byte;
          state_d = L_HI;
        end
      end
      L_HI: begin
        if (accept) begin
          hi_d    = ld_byte;
          state_d = L_LO;
        end
      end
      L_LO: begin
        if (accept) begin
          ld_wr   = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          wl_d    = wl_q + 1'b1;
          state_d = (wl_d == n_total) ? L_FIN : L_HI;
        end
      end
      L_FIN:   state_d = L_IDLE;
      default: state_d = L_IDLE;
    endcase
    // Abort beats a same-cycle byte accept: nothing from this cycle is committed.
    if (ld_abort && (state_q != L_IDLE)) begin
      state_d = L_IDLE;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      wl_d    = wl_q;
      ld_wr   = 1'b0;
    end
  end

  assign cpu_hold     = (state_q != L_IDLE);
  assign ld_done      = (state_q == L_FIN);
  assign words_loaded = wl_q;

  // The CPU port is fenced whenever the loader owns the store, so the two writers never collide.
  assign ram_we    = ld_wr | (ce & we & ~cpu_hold);
  assign ram_addr  = cpu_hold ? ptr_q : address;
  assign ram_wdata = ld_wr ? {hi_q, ld_byte} : dataW;
  assign dataR     = (ce && !cpu_hold) ? ram_rdata : '0;

  nano_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .ck    (ck),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_nano_mem_loader.sv
// Self-checking bench for nano_mem_loader against a word-array reference of the store.
module tb_nano_mem_loader;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  address = '0;
  logic [15:0] dataW = '0;
  logic [15:0] dataR;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_abort = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_byte = '0;
  logic        cpu_hold;
  logic        ld_done;
  logic [8:0]  words_loaded;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [15:0] ref_mem [256];

  nano_mem_loader dut (
    .ck           (ck),
    .rst_n        (rst_n),
    .address      (address),
    .dataW        (dataW),
    .dataR        (dataR),
    .ce           (ce),
    .we           (we),
    .ld_start     (ld_start),
    .ld_abort     (ld_abort),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_byte      (ld_byte),
    .cpu_hold     (cpu_hold),
    .ld_done      (ld_done),
    .words_loaded (words_loaded)
  );

  always #5 ck = ~ck;

  always @(posedge ck) if (ld_done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    ce = 1'b1; we = 1'b1; address = a; dataW = d;
    step();
    ce = 1'b0; we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
    repeat (gap) begin
      ld_valid = 1'b0;
      step();
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    @(negedge ck);
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: ld_ready=%b while session awaits byte, want 1", tag, ld_ready);
    end
    step();
    ld_valid = 1'b0;
  endtask

  task automatic run_session(input logic [7:0] base, input logic [7:0] n,
                             input logic [15:0] words[$], input int maxgap, input string tag);
    int d0;
    int total;
    total = (n == 8'd0) ? 256 : int'(n);
    d0 = done_cnt;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    @(negedge ck);
    n_checks++;
    if (cpu_hold !== 1'b1 || words_loaded !== 9'd0) begin
      n_fail++;
      $display("FAIL %s_start: cpu_hold=%b words_loaded=%0d, want 1 and 0", tag, cpu_hold, words_loaded);
    end
    step();
    send_byte(base, $urandom_range(maxgap, 0), tag);
    send_byte(n, $urandom_range(maxgap, 0), tag);
    for (int i = 0; i < total; i++) begin
      send_byte(words[i][15:8], $urandom_range(maxgap, 0), tag);
      send_byte(words[i][7:0], $urandom_range(maxgap, 0), tag);
      ref_mem[8'(int'(base) + i)] = words[i];
    end
    @(negedge ck);
    n_checks++;
    if (ld_done !== 1'b1 || cpu_hold !== 1'b1 || ld_ready !== 1'b0 || words_loaded !== 9'(total)) begin
      n_fail++;
      $display("FAIL %s_fin: done=%b hold=%b ready=%b words=%0d, want 1 1 0 %0d",
               tag, ld_done, cpu_hold, ld_ready, words_loaded, total);
    end
    step();
    @(negedge ck);
    n_checks++;
    if (ld_done !== 1'b0 || cpu_hold !== 1'b0 || (done_cnt - d0) != 1) begin
      n_fail++;
      $display("FAIL %s_after: done=%b hold=%b pulses=%0d, want 0 0 1",
               tag, ld_done, cpu_hold, done_cnt - d0);
    end
    step();
  endtask

  task automatic test_mem_scan(input string tag);
    for (int i = 0; i < 256; i++) begin
      ce = 1'b1; we = 1'b0; address = 8'(i);
      @(negedge ck);
      n_checks++;
      if (dataR !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL %s_mem[%02h]: got %04h want %04h", tag, i, dataR, ref_mem[i]);
      end
      step();
    end
    ce = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ck);
    @(negedge ck);
    n_checks++;
    if (ld_ready !== 1'b0 || cpu_hold !== 1'b0 || ld_done !== 1'b0 || words_loaded !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b hold=%b done=%b words=%0d, want 0 0 0 0",
               ld_ready, cpu_hold, ld_done, words_loaded);
    end
    n_checks++;
    if (dataR !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_dataR: got %04h with ce=0, want 0000", dataR);
    end
    step();
    rst_n = 1'b1;
    step();
    @(negedge ck);
    n_checks++;
    if (cpu_hold !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: hold=%b ready=%b, want 0 0", cpu_hold, ld_ready);
    end
    step();
  endtask

  task automatic test_cpu_rw();
    for (int i = 0; i < 256; i++) cpu_write(8'(i), 16'($urandom));
    cpu_write(8'h10, 16'hBEEF);
    ce = 1'b1; we = 1'b0; address = 8'h10;
    @(negedge ck);
    n_checks++;
    if (dataR !== 16'hBEEF || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_rw_beef: dataR=%04h hold=%b, want BEEF 0", dataR, cpu_hold);
    end
    step();
    ce = 1'b0;
    test_mem_scan("preload");
  endtask

  task automatic test_load();
    logic [15:0] w[$];
    w = '{16'h1234, 16'hABCD};
    run_session(8'h20, 8'h02, w, 0, "load");
    ce = 1'b1; address = 8'h20;
    @(negedge ck);
    n_checks++;
    if (dataR !== 16'h1234) begin
      n_fail++;
      $display("FAIL load_mem20: got %04h want 1234", dataR);
    end
    step();
    address = 8'h21;
    @(negedge ck);
    n_checks++;
    if (dataR !== 16'hABCD) begin
      n_fail++;
      $display("FAIL load_mem21: got %04h want ABCD", dataR);
    end
    step();
    ce = 1'b0;
  endtask

  task automatic test_wrap_stall();
    logic [15:0] w[$];
    w = '{16'($urandom), 16'($urandom)};
    @(negedge ck);
    n_checks++;
    if (ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_idle_ready: got %b want 0", ld_ready);
    end
    step();
    run_session(8'hFF, 8'h02, w, 3, "wrap");
    ce = 1'b1; address = 8'hFF;
    @(negedge ck);
    n_checks++;
    if (dataR !== w[0]) begin
      n_fail++;
      $display("FAIL wrap_memFF: got %04h want %04h", dataR, w[0]);
    end
    step();
    address = 8'h00;
    @(negedge ck);
    n_checks++;
    if (dataR !== w[1]) begin
      n_fail++;
      $display("FAIL wrap_mem00: got %04h want %04h", dataR, w[1]);
    end
    step();
    ce = 1'b0;
  endtask

  task automatic test_fence();
    logic [15:0] wv;
    wv = 16'($urandom);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ce = 1'b1; we = 1'b1; address = 8'h05; dataW = 16'h5555;
    @(negedge ck);
    n_checks++;
    if (dataR !== 16'h0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL fence_read: dataR=%04h hold=%b, want 0000 1", dataR, cpu_hold);
    end
    step();
    send_byte(8'h30, 0, "fence");
    send_byte(8'h01, 1, "fence");
    send_byte(wv[15:8], 0, "fence");
    send_byte(wv[7:0], 2, "fence");
    ref_mem[8'h30] = wv;
    @(negedge ck);
    n_checks++;
    if (dataR !== 16'h0 || ld_done !== 1'b1) begin
      n_fail++;
      $display("FAIL fence_fin: dataR=%04h done=%b, want 0000 1", dataR, ld_done);
    end
    ce = 1'b0; we = 1'b0;
    step();
    step();
    ce = 1'b1; address = 8'h05;
    @(negedge ck);
    n_checks++;
    if (dataR !== ref_mem[8'h05]) begin
      n_fail++;
      $display("FAIL fence_mem05: got %04h want %04h", dataR, ref_mem[8'h05]);
    end
    step();
    address = 8'h30;
    @(negedge ck);
    n_checks++;
    if (dataR !== wv) begin
      n_fail++;
      $display("FAIL fence_mem30: got %04h want %04h", dataR, wv);
    end
    step();
    ce = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] w1, w2;
    int d0;
    w1 = 16'($urandom);
    w2 = ~ref_mem[8'h41];
    d0 = done_cnt;
    ld_start = 1'b1; ld_abort = 1'b1;
    step();
    ld_start = 1'b0; ld_abort = 1'b0;
    @(negedge ck);
    n_checks++;
    if (cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: hold=%b after start+abort in idle, want 1", cpu_hold);
    end
    step();
    send_byte(8'h40, 0, "abort");
    send_byte(8'h03, 0, "abort");
    send_byte(w1[15:8], 1, "abort");
    send_byte(w1[7:0], 0, "abort");
    ref_mem[8'h40] = w1;
    send_byte(w2[15:8], 0, "abort");
    ld_valid = 1'b1; ld_byte = w2[7:0]; ld_abort = 1'b1;
    step();
    ld_valid = 1'b0; ld_abort = 1'b0;
    @(negedge ck);
    n_checks++;
    if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || words_loaded !== 9'd1 || ld_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: hold=%b ready=%b words=%0d done=%b, want 0 0 1 0",
               cpu_hold, ld_ready, words_loaded, ld_done);
    end
    step();
    step();
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d ld_done pulses, want 0", done_cnt - d0);
    end
    ce = 1'b1; address = 8'h40;
    @(negedge ck);
    n_checks++;
    if (dataR !== w1) begin
      n_fail++;
      $display("FAIL abort_mem40: got %04h want %04h", dataR, w1);
    end
    step();
    address = 8'h41;
    @(negedge ck);
    n_checks++;
    if (dataR !== ref_mem[8'h41]) begin
      n_fail++;
      $display("FAIL abort_mem41: got %04h want %04h", dataR, ref_mem[8'h41]);
    end
    step();
    ce = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    logic [7:0]  n;
    for (int k = 0; k < 4; k++) begin
      w.delete();
      n = (k == 3) ? 8'd0 : 8'($urandom_range(8, 1));
      for (int i = 0; i < ((n == 8'd0) ? 256 : int'(n)); i++) w.push_back(16'($urandom));
      run_session(8'($urandom), n, w, (k == 3) ? 0 : 2, "rand");
    end
    test_mem_scan("rand");
  endtask

  task automatic test_reset_mid();
    logic [15:0] w1;
    w1 = 16'($urandom);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    step();
    send_byte(8'h60, 0, "rstmid");
    send_byte(8'h02, 0, "rstmid");
    send_byte(w1[15:8], 0, "rstmid");
    send_byte(w1[7:0], 0, "rstmid");
    ref_mem[8'h60] = w1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: hold=%b ready=%b done=%b, want 0 0 0", cpu_hold, ld_ready, ld_done);
    end
    step();
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_byte = 8'hA5;
    step();
    @(negedge ck);
    n_checks++;
    if (ld_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: ready=%b hold=%b after reset, want 0 0", ld_ready, cpu_hold);
    end
    step();
    ld_valid = 1'b0;
    test_mem_scan("rstmid");
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_load();
    test_wrap_stall();
    test_fence();
    test_abort();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
